// File: rtl/frame_decoder_pkg.sv
// Shared framing constants and type encodings for the frame decoder and its CRC helper.
package frame_decoder_pkg;

    localparam logic [7:0]  SYNC_CHAR = 8'h7E;
    localparam logic [7:0]  MIN_LEN   = 8'd5;
    localparam logic [7:0]  MAX_LEN   = 8'd64;
    localparam logic [3:0]  SEQ_HI    = 4'h1;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC_POLY  = 16'h8408;

    typedef enum logic [2:0] {
        StSof  = 3'd0,
        StSeq  = 3'd1,
        StData = 3'd2,
        StCrc1 = 3'd3,
        StCrc2 = 3'd4,
        StEof  = 3'd5,
        StHunt = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ErrNone = 3'd0,
        ErrLen  = 3'd1,
        ErrCrc  = 3'd2,
        ErrSeq  = 3'd3,
        ErrEof  = 3'd4,
        ErrOvf  = 3'd5
    } err_e;

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Reflected CRC-16/CCITT advanced by one full byte, LSB first.
module crc16_ccitt_byte
    import frame_decoder_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/frame_decoder.sv
// Parses len/seq/payload/crc/sync frames into a payload ring; a frame's bytes become
// visible only once length, CRC and sequence checks all pass.
module frame_decoder
    import frame_decoder_pkg::*;
#(
    parameter int unsigned RING_BITS = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_rd_en,
    output logic [3:0] ack_seq,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code
);

    localparam int unsigned Depth = 2 ** RING_BITS;
    typedef logic [RING_BITS-1:0] ptr_t;
    localparam ptr_t PtrOne = ptr_t'(1);

    state_e      state_q;
    ptr_t        rptr_q;
    ptr_t        wptr_q;
    ptr_t        tmp_wptr_q;
    logic [5:0]  len_q;
    logic [5:0]  cnt_q;
    logic [7:0]  seq_q;
    logic [15:0] crc_q;
    logic [15:0] crc_rx_q;
    logic [3:0]  ack_seq_q;
    logic        frame_ok_q;
    logic        frame_err_q;
    err_e        err_q;

    logic [8:0]  ring [Depth];

    logic [15:0] crc_in;
    logic [15:0] crc_next;
    logic        ring_full;
    logic        ring_we;
    logic        pop;

    // A new frame seeds the CRC from the init value rather than the running register.
    assign crc_in = (state_q == StSof) ? CRC_INIT : crc_q;

    crc16_ccitt_byte u_crc (
        .crc_in  (crc_in),
        .data    (in_data),
        .crc_out (crc_next)
    );

    assign ring_full = (tmp_wptr_q + PtrOne) == rptr_q;
    assign ring_we   = in_valid && (state_q == StData) && !ring_full;
    assign pop       = out_rd_en && out_valid;

    // Payload storage has no reset; only pointers define what is valid.
    always_ff @(posedge clk) begin
        if (ring_we) begin
            ring[tmp_wptr_q] <= {cnt_q == 6'd1, in_data};
        end
    end

    assign out_data  = ring[rptr_q][7:0];
    assign out_last  = ring[rptr_q][8];
    assign out_valid = rptr_q != wptr_q;
    assign ack_seq   = ack_seq_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StSof;
            rptr_q      <= '0;
            wptr_q      <= '0;
            tmp_wptr_q  <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            seq_q       <= '0;
            crc_q       <= CRC_INIT;
            crc_rx_q    <= '0;
            ack_seq_q   <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_q       <= ErrNone;
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (pop) begin
                rptr_q <= rptr_q + PtrOne;
            end

            if (in_valid) begin
                unique case (state_q)
                    StSof: begin
                        tmp_wptr_q <= wptr_q;
                        if (in_data == SYNC_CHAR) begin
                            state_q <= StSof;
                        end else if (in_data < MIN_LEN || in_data >= MAX_LEN) begin
                            frame_err_q <= 1'b1;
                            err_q       <= ErrLen;
                            state_q     <= StHunt;
                        end else begin
                            len_q   <= in_data[5:0];
                            crc_q   <= crc_next;
                            state_q <= StSeq;
                        end
                    end
                    StSeq: begin
                        seq_q   <= in_data;
                        crc_q   <= crc_next;
                        cnt_q   <= len_q - 6'd5;
                        state_q <= (len_q == 6'd5) ? StCrc1 : StData;
                    end
                    StData: begin
                        if (ring_full) begin
                            frame_err_q <= 1'b1;
                            err_q       <= ErrOvf;
                            tmp_wptr_q  <= wptr_q;
                            state_q     <= StHunt;
                        end else begin
                            tmp_wptr_q <= tmp_wptr_q + PtrOne;
                            crc_q      <= crc_next;
                            cnt_q      <= cnt_q - 6'd1;
                            if (cnt_q == 6'd1) begin
                                state_q <= StCrc1;
                            end
                        end
                    end
                    StCrc1: begin
                        crc_rx_q[15:8] <= in_data;
                        state_q        <= StCrc2;
                    end
                    StCrc2: begin
                        crc_rx_q[7:0] <= in_data;
                        state_q       <= StEof;
                    end
                    StEof: begin
                        if (in_data != SYNC_CHAR) begin
                            frame_err_q <= 1'b1;
                            err_q       <= ErrEof;
                            tmp_wptr_q  <= wptr_q;
                            state_q     <= StHunt;
                        end else if (crc_q != crc_rx_q) begin
                            frame_err_q <= 1'b1;
                            err_q       <= ErrCrc;
                            tmp_wptr_q  <= wptr_q;
                            state_q     <= StSof;
                        end else if (seq_q[7:4] != SEQ_HI || seq_q[3:0] != ack_seq_q) begin
                            frame_err_q <= 1'b1;
                            err_q       <= ErrSeq;
                            tmp_wptr_q  <= wptr_q;
                            state_q     <= StSof;
                        end else begin
                            wptr_q     <= tmp_wptr_q;
                            ack_seq_q  <= seq_q[3:0] + 4'd1;
                            frame_ok_q <= 1'b1;
                            state_q    <= StSof;
                        end
                    end
                    StHunt: begin
                        if (in_data == SYNC_CHAR) begin
                            state_q <= StSof;
                        end
                    end
                    default: begin
                        state_q <= StHunt;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_decoder.sv
// Directed bench for frame_decoder with event and payload scoreboards.
module tb_frame_decoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       out_rd_en;
    logic [3:0] ack_seq;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;

    int checks = 0;
    int errors = 0;

    logic [2:0] ev_q[$];
    logic [8:0] data_q[$];
    logic [7:0] pl_q[$];

    frame_decoder #(
        .RING_BITS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_rd_en (out_rd_en),
        .ack_seq   (ack_seq),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: feedback is crc[0] xor the next data bit, LSB first.
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[15:1]};
            if (fb) r = r ^ 16'h8408;
        end
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] seq, input logic [7:0] crc_flip,
                              input logic [7:0] eof, input logic [2:0] exp_code);
        logic [15:0] c;
        logic [7:0]  len;
        int          n;
        n   = pl_q.size();
        len = 8'(n + 5);
        c   = crc_model(16'hFFFF, len);
        c   = crc_model(c, seq);
        for (int i = 0; i < n; i++) c = crc_model(c, pl_q[i]);
        ev_q.push_back(exp_code);
        if (exp_code == 3'd0) begin
            for (int i = 0; i < n; i++) data_q.push_back({i == n - 1, pl_q[i]});
        end
        send_byte(len);
        send_byte(seq);
        for (int i = 0; i < n; i++) send_byte(pl_q[i]);
        send_byte(c[15:8]);
        send_byte(c[7:0] ^ crc_flip);
        send_byte(eof);
        pl_q.delete();
    endtask

    task automatic wait_events();
        for (int i = 0; i < 30 && ev_q.size() != 0; i++) @(negedge clk);
        check("evt_pending", 32'(ev_q.size()), 32'd0);
    endtask

    task automatic drain();
        logic [8:0] exp;
        out_rd_en = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!out_valid) break;
            check("pop_expected", 32'(data_q.size() > 0), 32'd1);
            if (data_q.size() > 0) begin
                exp = data_q.pop_front();
                check("pop_byte", 32'({out_last, out_data}), 32'(exp));
            end
            out_rd_en = 1'b1;
        end
        out_rd_en = 1'b0;
        check("drain_left", 32'(data_q.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        logic [2:0] exp;
        #1;
        if (frame_ok || frame_err) begin
            check("ok_err_exclusive", 32'(frame_ok & frame_err), 32'd0);
            check("evt_expected", 32'(ev_q.size() > 0), 32'd1);
            if (ev_q.size() > 0) begin
                exp = ev_q.pop_front();
                check("evt_outcome", 32'({frame_ok, frame_err, frame_err ? err_code : 3'd0}),
                      32'({exp == 3'd0, exp != 3'd0, exp}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_rd_en = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ack_seq", 32'(ack_seq), 32'd0);
        check("rst_frame_ok", 32'(frame_ok), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Bad CRC on an otherwise good frame
        pl_q = '{8'hA1, 8'hB2, 8'hC3};
        send_frame(8'h10, 8'h01, 8'h7E, 3'd2);
        wait_events();
        check("crc_err_valid", 32'(out_valid), 32'd0);
        check("crc_err_ack", 32'(ack_seq), 32'd0);

        // Good frame
        pl_q = '{8'hA1, 8'hB2, 8'hC3};
        send_frame(8'h10, 8'h00, 8'h7E, 3'd0);
        wait_events();
        check("good_ack", 32'(ack_seq), 32'd1);
        drain();

        // Sequence errors, then the right sequence number
        pl_q = '{8'h11, 8'h22};
        send_frame(8'h12, 8'h00, 8'h7E, 3'd3);
        pl_q = '{8'h11, 8'h22};
        send_frame(8'h11, 8'h00, 8'h7E, 3'd0);
        wait_events();
        check("seq_ack", 32'(ack_seq), 32'd2);
        drain();

        // Length errors with hunting; bytes before sync are discarded
        ev_q.push_back(3'd1);
        send_byte(8'h03);
        send_byte(8'h08);
        send_byte(8'h10);
        send_byte(8'h7E);
        ev_q.push_back(3'd1);
        send_byte(8'h40);
        send_byte(8'h7E);
        pl_q = '{8'h55};
        send_frame(8'h12, 8'h00, 8'h7E, 3'd0);
        wait_events();
        check("len_ack", 32'(ack_seq), 32'd3);
        drain();

        // Empty frame only advances ack_seq
        send_frame(8'h13, 8'h00, 8'h7E, 3'd0);
        wait_events();
        check("empty_ack", 32'(ack_seq), 32'd4);
        check("empty_valid", 32'(out_valid), 32'd0);

        // Pop on an empty ring is ignored
        out_rd_en = 1'b1;
        repeat (3) @(negedge clk);
        out_rd_en = 1'b0;
        @(negedge clk);
        check("empty_pop_valid", 32'(out_valid), 32'd0);

        // Wrong high nibble in seq
        send_frame(8'h24, 8'h00, 8'h7E, 3'd3);
        // Bad end-of-frame byte, then resync
        pl_q = '{8'h99, 8'h88};
        send_frame(8'h14, 8'h00, 8'h55, 3'd4);
        send_byte(8'h7E);
        wait_events();
        check("eof_ack", 32'(ack_seq), 32'd4);
        check("eof_valid", 32'(out_valid), 32'd0);

        // Overflow: commit a frame, then a frame too large for the remaining space
        pl_q = '{8'hD1, 8'hD2, 8'hD3};
        send_frame(8'h14, 8'h00, 8'h7E, 3'd0);
        wait_events();
        ev_q.push_back(3'd5);
        send_byte(8'd15);
        send_byte(8'h15);
        for (int i = 1; i <= 10; i++) send_byte(8'(i));
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h7E);
        wait_events();
        check("ovf_ack", 32'(ack_seq), 32'd5);
        drain();

        // Reset in the middle of a payload
        send_byte(8'd8);
        send_byte(8'h15);
        send_byte(8'hAA);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ack", 32'(ack_seq), 32'd0);
        check("midrst_ok", 32'(frame_ok), 32'd0);
        check("midrst_err", 32'(frame_err), 32'd0);
        check("midrst_code", 32'(err_code), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pl_q = '{8'h5A, 8'h6B};
        send_frame(8'h10, 8'h00, 8'h7E, 3'd0);
        wait_events();
        check("postrst_ack", 32'(ack_seq), 32'd1);
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_decoder.md
FRAME_DECODER -- requirements
Module: frame_decoder

Interface
REQ-001 SHALL have parameter RING_BITS, default 6: log2 depth of the payload ring.
REQ-002 SHALL have port clk, input, 1: sole clock; all logic on posedge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port in_data, input, 8: received UART byte.
REQ-005 SHALL have port in_valid, input, 1: one-cycle strobe; in_data is valid this cycle, with no backpressure.
REQ-006 SHALL have port out_data, output, 8: payload byte at the ring head.
REQ-007 SHALL have port out_last, output, 1: out_data is the final payload byte of its frame.
REQ-008 SHALL have port out_valid, output, 1: the ring holds at least one committed byte.
REQ-009 SHALL have port out_rd_en, input, 1: pops the head byte when out_valid=1.
REQ-010 SHALL have port ack_seq, output, 4: next expected sequence number.
REQ-011 SHALL have port frame_ok, output, 1: one-cycle pulse when a frame commits.
REQ-012 SHALL have port frame_err, output, 1: one-cycle pulse when a frame is dropped.
REQ-013 SHALL have port err_code, output, 3: drop cause, valid with frame_err; 1=len, 2=crc, 3=seq, 4=eof, 5=overflow.

Function
REQ-014 SHALL decode frames in this order: len, seq, len-5 payload bytes, crc_hi, crc_lo, 0x7E.
REQ-015 SHALL use states SOF, SEQ, DATA, CRC1, CRC2, EOF, HUNT, advancing only on in_valid.
REQ-016 SOF SHALL ignore 0x7E and drop on len<5 or len>=64 (err 1, ->HUNT); otherwise it SHALL start the CRC and copy wptr into tmp_wptr.
REQ-017 SEQ SHALL go to CRC1 when len==5, else to DATA.
REQ-018 DATA SHALL write {last,byte} at tmp_wptr, setting last on the final payload byte, and go to CRC1 after len-5 bytes.
REQ-019 If the ring is full (tmp_wptr+1==rptr) when a DATA byte arrives, SHALL drop with err 5 and go ->HUNT.
REQ-020 CRC SHALL be reflected CCITT (poly 0x8408 shifted right), init 0xFFFF, over len, seq and payload, updated one full byte per cycle.
REQ-021 Received CRC SHALL be compared as {crc_hi,crc_lo}.
REQ-022 EOF byte !=0x7E SHALL drop with err 4 and go ->HUNT.
REQ-023 On EOF byte ==0x7E, checks SHALL run in priority order: CRC (err 2), then seq[7:4]!=4'h1 or seq[3:0]!=ack_seq (err 3); any failure drops and goes ->SOF.
REQ-024 A passing frame SHALL set wptr<=tmp_wptr, ack_seq<=seq+1 (mod 16), pulse frame_ok and go ->SOF.
REQ-025 HUNT SHALL discard bytes until 0x7E, then go ->SOF.
REQ-026 Every drop SHALL restore tmp_wptr<=wptr, so committed data is never disturbed.
REQ-027 Empty frames (len 5) SHALL only advance ack_seq and pulse frame_ok.
REQ-028 out_data/out_last SHALL be combinational from ring[rptr]; out_valid SHALL equal rptr!=wptr; a pop SHALL advance rptr next cycle.
REQ-029 Pointers SHALL wrap mod 2^RING_BITS; simultaneous pop and commit SHALL both take effect.
REQ-030 out_rd_en with out_valid=0 SHALL be ignored.
REQ-031 frame_ok and frame_err SHALL never assert in the same cycle.

Reset
REQ-032 rst_n=0 SHALL clear asynchronously: state=SOF, rptr=wptr=tmp_wptr=0, ack_seq=0, CRC=0xFFFF, out_valid=0, frame_ok=0, frame_err=0, err_code=0.
REQ-033 Reset mid-frame SHALL discard the partial frame; ring contents need no reset.

Structure
REQ-034 SYNC_CHAR=8'h7E, MIN_LEN=5, MAX_LEN=64, SEQ_HI=4'h1, state encodings and err codes SHALL live in a shared framing package also used by framing.
REQ-035 Byte-wide CRC update SHALL be a sub-module crc16_ccitt_byte, combinational, (crc_in, data) -> crc_out.

Verification
REQ-036 Send len=8, seq=0x10, payload 0xA1 0xB2 0xC3, correct CRC, 0x7E -> frame_ok once, popping yields A1,B2,C3 with out_last only on C3, ack_seq=1.
REQ-037 Send the same frame with crc_lo^=0x01 -> frame_err with err_code=2, out_valid stays 0, ack_seq stays 0.
REQ-038 Send len=0x03 and later len=0x40 -> err_code=1 and HUNT; then 0x7E plus a valid frame -> frame_ok.
REQ-039 Send a valid frame with seq=0x12 while ack_seq=1 -> err_code=3; resend with seq=0x11 -> frame_ok, ack_seq=2.
REQ-040 With RING_BITS=3, send a 10-byte payload frame without popping -> err_code=5, ring is not corrupted, and an earlier committed frame reads back intact.
REQ-041 Assert rst_n low mid-DATA -> all outputs at reset values; a following valid frame with seq=0x10 commits.
